// File: rtl/vga_cmd_unit.sv
// vga_cmd_unit: queues VGA sprite/font/background commands and applies them during vertical blanking.
module vga_cmd_unit #(
  parameter int DEPTH = 4,
  parameter int NSPR  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spriteE,
  input  logic                    fontE,
  input  logic                    backgroundE,
  input  logic                    posE,
  input  logic                    attrE,
  input  logic                    visiE,
  input  logic                    stallE,
  input  logic [31:0]             srcaE,
  input  logic [31:0]             srcbE,
  input  logic                    vblank,
  output logic                    vga_stall,
  output logic                    busy,
  input  logic [$clog2(NSPR)-1:0] spr_rd_idx,
  output logic [9:0]              spr_x,
  output logic [9:0]              spr_y,
  output logic [7:0]              spr_attr,
  output logic                    spr_vis,
  output logic [11:0]             bg_color,
  output logic                    font_we,
  output logic [11:0]             font_addr,
  output logic [7:0]              font_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(NSPR);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [1:0] IDLE = 2'd0, WAIT_BLANK = 2'd1, DRAIN = 2'd2;
  localparam logic [1:0] T_SPR = 2'd1, T_FONT = 2'd2, T_BG = 2'd3;
  logic [1:0]  type_mem [DEPTH];
  logic [2:0]  sel_mem  [DEPTH];
  logic [11:0] a_mem    [DEPTH];
  logic [31:0] b_mem    [DEPTH];
  logic [9:0]  x_q [NSPR];
  logic [9:0]  y_q [NSPR];
  logic [7:0]  attr_q [NSPR];
  logic        vis_q [NSPR];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [11:0]   bg_q, font_addr_q;
  logic [7:0]    font_data_q;
  logic          font_we_q;
  logic          cmd_valid, full, push, pop;
  logic [1:0]    cmd_type, h_type;
  logic [2:0]    h_sel;
  logic [11:0]   h_a;
  logic [31:0]   h_b;
  logic [IW-1:0] h_idx;
  logic          unused_bits;
  assign cmd_valid = spriteE | fontE | backgroundE;
  assign cmd_type  = spriteE ? T_SPR : fontE ? T_FONT : T_BG;
  assign full      = count_q == FULL_CNT;
  assign vga_stall = cmd_valid & full;
  assign push      = cmd_valid & ~full & ~stallE;
  assign pop       = (state_q == DRAIN) & (count_q != '0);
  assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign state_d   = (count_d == '0) ? IDLE : vblank ? DRAIN : WAIT_BLANK;
  assign h_type    = type_mem[rd_ptr_q];
  assign h_sel     = sel_mem[rd_ptr_q];
  assign h_a       = a_mem[rd_ptr_q];
  assign h_b       = b_mem[rd_ptr_q];
  assign h_idx     = h_a[IW-1:0];
  assign unused_bits = ^{srcaE[31:12], h_b[30:28]};
  assign busy      = state_q != IDLE;
  assign spr_x     = x_q[spr_rd_idx];
  assign spr_y     = y_q[spr_rd_idx];
  assign spr_attr  = attr_q[spr_rd_idx];
  assign spr_vis   = vis_q[spr_rd_idx];
  assign bg_color  = bg_q;
  assign font_we   = font_we_q;
  assign font_addr = font_addr_q;
  assign font_data = font_data_q;
  // Queue storage carries no reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[wr_ptr_q] <= cmd_type;
      sel_mem[wr_ptr_q]  <= {posE, attrE, visiE};
      a_mem[wr_ptr_q]    <= srcaE[11:0];
      b_mem[wr_ptr_q]    <= srcbE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      bg_q        <= '0;
      font_we_q   <= 1'b0;
      font_addr_q <= '0;
      font_data_q <= '0;
      for (int i = 0; i < NSPR; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        attr_q[i] <= '0;
        vis_q[i]  <= 1'b0;
      end
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      state_q   <= state_d;
      font_we_q <= pop && h_type == T_FONT;
      if (pop && h_type == T_FONT) begin
        font_addr_q <= h_a;
        font_data_q <= h_b[7:0];
      end
      if (pop && h_type == T_BG) bg_q <= h_b[11:0];
      if (pop && h_type == T_SPR) begin
        if (h_sel[2]) begin
          x_q[h_idx] <= h_b[9:0];
          y_q[h_idx] <= h_b[19:10];
        end
        if (h_sel[1]) attr_q[h_idx] <= h_b[27:20];
        if (h_sel[0]) vis_q[h_idx] <= h_b[31];
      end
    end
  end
endmodule

// File: tb/tb_vga_cmd_unit.sv
// tb_vga_cmd_unit: directed checks of queuing, blanking-gated apply, back-pressure and reset.
module tb_vga_cmd_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        spriteE = 0, fontE = 0, backgroundE = 0, posE = 0, attrE = 0, visiE = 0;
  logic        stall_drv = 0, tie = 0, vblank = 0;
  logic        stallE;
  logic [31:0] srcaE = 0, srcbE = 0;
  logic [2:0]  spr_rd_idx = 0;
  logic        vga_stall, busy, spr_vis, font_we;
  logic [9:0]  spr_x, spr_y;
  logic [7:0]  spr_attr, font_data;
  logic [11:0] bg_color, font_addr;
  int checks = 0, errors = 0;
  assign stallE = tie ? vga_stall : stall_drv;
  always #5 clk = ~clk;
  vga_cmd_unit #(.DEPTH(4), .NSPR(8)) dut (
    .clk(clk), .reset(reset), .spriteE(spriteE), .fontE(fontE), .backgroundE(backgroundE),
    .posE(posE), .attrE(attrE), .visiE(visiE), .stallE(stallE), .srcaE(srcaE), .srcbE(srcbE),
    .vblank(vblank), .vga_stall(vga_stall), .busy(busy), .spr_rd_idx(spr_rd_idx),
    .spr_x(spr_x), .spr_y(spr_y), .spr_attr(spr_attr), .spr_vis(spr_vis), .bg_color(bg_color),
    .font_we(font_we), .font_addr(font_addr), .font_data(font_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_spr(input int idx, input logic [9:0] x, input logic [9:0] y, input logic [7:0] a, input logic v);
    spr_rd_idx = 3'(idx);
    #1;
    chk($sformatf("spr%0d", idx), {1'b0, spr_x, spr_y, spr_attr, spr_vis}, {1'b0, x, y, a, v});
  endtask
  initial begin
    int n;
    logic pushing;
    tick();
    tick();
    reset = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_bg", bg_color, 0);
    chk("rst_font", {font_we, font_addr, font_data}, 0);
    chk("rst_stall", vga_stall, 0);
    chk("rst_count", dut.count_q, 0);
    for (int i = 0; i < 8; i++) chk_spr(i, 0, 0, 0, 0);
    // sprite write with all selects during blanking
    vblank = 1; spriteE = 1; posE = 1; attrE = 1; visiE = 1; srcaE = 3; srcbE = 32'h8A50C864;
    tick();
    spriteE = 0; posE = 0; attrE = 0; visiE = 0;
    chk("spr_state_drain", dut.state_q, 2);
    tick();
    chk_spr(3, 10'h064, 10'h032, 8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) if (i != 3) chk_spr(i, 0, 0, 0, 0);
    chk("spr_idle", busy, 0);
    // background held until blanking
    vblank = 0; backgroundE = 1; srcbE = 32'h00000F0F;
    tick();
    backgroundE = 0;
    repeat (20) tick();
    chk("hold_bg", bg_color, 0);
    chk("hold_busy", busy, 1);
    vblank = 1;
    tick();
    chk("hold_bg_pre", bg_color, 0);
    tick();
    chk("hold_bg_post", bg_color, 12'hF0F);
    chk("hold_busy_post", busy, 0);
    // fill the queue and stall the fifth font command
    vblank = 0;
    for (int i = 0; i < 4; i++) begin
      fontE = 1; srcaE = 32'h100 + i; srcbE = 32'h10 + i;
      tick();
    end
    srcaE = 32'h104; srcbE = 32'h14;
    #1;
    chk("full_stall", vga_stall, 1);
    chk("full_count", dut.count_q, 4);
    tie = 1; vblank = 1; n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      pushing = fontE && !vga_stall;
      tick();
      if (pushing) fontE = 0;
      if (font_we) begin
        chk($sformatf("font_addr%0d", n), font_addr, 32'h100 + n);
        chk($sformatf("font_data%0d", n), font_data, 32'h10 + n);
        n++;
      end
    end
    chk("font_pulses", n, 5);
    tick();
    chk("font_we_done", font_we, 0);
    chk("font_idle", busy, 0);
    tie = 0; vblank = 0;
    // command held in E by stallE enters the queue once
    spriteE = 1; posE = 1; stall_drv = 1; srcaE = 5; srcbE = 32'hFFF00123;
    repeat (3) tick();
    chk("stall_count0", dut.count_q, 0);
    stall_drv = 0;
    tick();
    spriteE = 0; posE = 0;
    chk("stall_count1", dut.count_q, 1);
    repeat (2) tick();
    chk("stall_count_hold", dut.count_q, 1);
    vblank = 1;
    tick();
    tick();
    chk_spr(5, 10'h123, 10'h000, 8'h00, 1'b0);
    chk("stall_drained", dut.count_q, 0);
    // reset while draining
    vblank = 0;
    for (int i = 0; i < 3; i++) begin
      fontE = 1; srcaE = 32'h200 + i; srcbE = 32'h20 + i;
      tick();
    end
    fontE = 0;
    chk("mid_count3", dut.count_q, 3);
    vblank = 1;
    tick();
    tick();
    chk("mid_count2", dut.count_q, 2);
    reset = 1;
    tick();
    chk("mid_count", dut.count_q, 0);
    chk("mid_state", dut.state_q, 0);
    chk("mid_font_we", font_we, 0);
    chk("mid_bg", bg_color, 0);
    for (int i = 0; i < 8; i++) chk_spr(i, 0, 0, 0, 0);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_font_we", font_we, 0);
      chk("post_busy", busy, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
